// File: rtl/ram_rd_burst_reader.sv
// ram_rd_burst_reader
// Descriptor-driven read engine for one read channel of the simple dual-port
// frame RAM. A (start address, word count) descriptor turns into one RAM read
// per cycle. The returning words pass through a latency pipeline into a
// 4-entry FIFO and leave as a valid/ready stream with a last flag.
//
// Build option RD_OUTREG_EN: define it when the RAM runs with its output
// register (HIGH_PERFORMANCE). Read latency is then 2 and ram_regce follows
// ram_en one cycle later. When it is undefined, latency is 1 (LOW_LATENCY RAM)
// and ram_regce is tied low.
//
// Reads are credit limited. A credit is taken when a read is issued and is
// handed back when the word leaves on the stream. At most 4 words can
// therefore be in the pipeline or the FIFO at once, so the FIFO cannot
// overflow.
//
// state   | meaning
// S_IDLE  | no burst active; desc_ready high one cycle after reset or after a zero-length descriptor
// S_READ  | issuing sequential reads while credits remain
// S_DRAIN | every read issued; waiting for the last word to leave the stream

module ram_rd_burst_reader #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 16,
    parameter int LEN_WIDTH = 12,
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [AW-1:0]        desc_addr,
    input  logic [LEN_WIDTH-1:0] desc_len,
    output logic                 ram_en,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_regce,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

`ifdef RD_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int              FIFO_DEPTH = 4;
    localparam logic [2:0]      CREDIT_MAX = 3'd4;
    localparam logic [AW-1:0]   ADDR_LAST  = AW'(RAM_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] rem;
    logic [2:0]           credits;
    logic                 ram_last;

    logic [LAT-1:0]       pipe_v;
    logic [LAT-1:0]       pipe_l;

    logic [RAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           fifo_cnt;

    logic                 desc_hs;
    logic                 m_hs;
    logic                 final_hs;
    logic                 fifo_wr;
    logic                 issue;
    logic                 issue_last;
    logic [AW-1:0]        addr_inc;

    assign desc_hs  = desc_valid & desc_ready;
    assign m_hs     = m_valid & m_ready;
    assign final_hs = m_hs & m_last;
    assign fifo_wr  = pipe_v[LAT-1];

    // RAM_DEPTH need not be a power of two, so the wrap uses an explicit compare.
    assign addr_inc = (ram_addr == ADDR_LAST) ? '0 : ram_addr + AW'(1);

    // Decide whether a read is issued next cycle and whether it is the burst's final read.
    // A credit returned in the same cycle may be reused at once, which keeps a
    // 2-cycle-latency RAM streaming without bubbles.
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            S_IDLE: begin
                issue      = desc_hs && (desc_len != '0);
                issue_last = (desc_len == LEN_WIDTH'(1));
            end
            S_READ: begin
                issue      = (credits != 3'd0) || m_hs;
                issue_last = (rem == LEN_WIDTH'(1));
            end
            default: begin
                issue      = 1'b0;
                issue_last = 1'b0;
            end
        endcase
    end

    // Burst FSM, with the read-port drive and the descriptor handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            desc_ready <= 1'b0;
            done       <= 1'b0;
            ram_en     <= 1'b0;
            ram_last   <= 1'b0;
            ram_addr   <= '0;
            rem        <= '0;
        end else begin
            done     <= 1'b0;
            ram_en   <= issue;
            ram_last <= issue & issue_last;
            case (state)
                S_IDLE: begin
                    // desc_ready is registered. It drops for one cycle after any
                    // accepted descriptor, so a zero-length one is also seen as consumed.
                    desc_ready <= !desc_hs;
                    if (desc_hs) begin
                        if (desc_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            ram_addr <= desc_addr;
                            rem      <= desc_len - LEN_WIDTH'(1);
                            state    <= (desc_len == LEN_WIDTH'(1)) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        ram_addr <= addr_inc;
                        rem      <= rem - LEN_WIDTH'(1);
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Words leave in order, so once the last word has been taken
                    // the pipeline and the FIFO are already empty.
                    if (final_hs) begin
                        state      <= S_IDLE;
                        desc_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Credit counter: minus one per issued read, plus one per stream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CREDIT_MAX;
        end else begin
            credits <= credits - {2'b00, issue} + {2'b00, m_hs};
        end
    end

    // Latency pipeline: marks the cycle when ram_dout holds a requested word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_l <= '0;
        end else begin
`ifdef RD_OUTREG_EN
            pipe_v <= {pipe_v[0], ram_en};
            pipe_l <= {pipe_l[0], ram_last};
`else
            pipe_v <= ram_en;
            pipe_l <= ram_last;
`endif
        end
    end

`ifdef RD_OUTREG_EN
    assign ram_regce = pipe_v[0];
`else
    assign ram_regce = 1'b0;
`endif

    // Skid FIFO: takes each word as it leaves the pipeline and holds the head
    // steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= pipe_l[LAT-1];
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (m_hs) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + {2'b00, fifo_wr} - {2'b00, m_hs};
        end
    end

    assign m_valid = (fifo_cnt != 3'd0);
    assign m_data  = fifo_data[rd_ptr];
    // Gated by m_valid so that a stale flag from the previous burst never shows.
    assign m_last  = m_valid & fifo_last[rd_ptr];
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_ram_rd_burst_reader.sv
// Directed testbench for ram_rd_burst_reader. It models the frame RAM read
// port, records every cycle at the negedge, and checks the results of each scenario.
module tb_ram_rd_burst_reader;

`ifdef RD_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [3:0]  desc_addr = '0;
    logic [11:0] desc_len = '0;
    logic        ram_en;
    logic [3:0]  ram_addr;
    logic        ram_regce;
    logic [31:0] ram_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ram_rd_burst_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_regce  (ram_regce),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    logic [31:0] mem [16];

`ifdef RD_OUTREG_EN
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_en)    ram_q    <= mem[ram_addr];
        if (ram_regce) ram_dout <= ram_q;
    end
`else
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int cyc = 0;
    int k_cyc, first_en_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    int n_done, n_regce, n_issued, n_hs, n_last, n_busy, max_out;
    logic dr_at_done;
    logic [31:0] got_d[$];
    bit          got_l[$];
    int          addr_q[$];

    task automatic rec_clear();
        first_en_cyc = -1; first_valid_cyc = -1; first_hs_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1; k_cyc = -1;
        n_done = 0; n_regce = 0; n_issued = 0; n_hs = 0; n_last = 0;
        n_busy = 0; max_out = 0; dr_at_done = 1'b0;
        got_d.delete(); got_l.delete(); addr_q.delete();
    endtask

    // One clock: drive at the negedge, then record what the next posedge will see.
    task automatic step(input bit rdy);
        @(negedge clk);
        cyc++;
        desc_valid = 1'b0;
        m_ready    = rdy;
        #1;
        if (ram_en) begin
            addr_q.push_back(int'(ram_addr));
            if (first_en_cyc < 0) first_en_cyc = cyc;
            n_issued++;
        end
        if (ram_regce) n_regce++;
        if (busy) n_busy++;
        if (n_issued - n_hs > max_out) max_out = n_issued - n_hs;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            if (n_hs == 0) first_hs_cyc = cyc;
            n_hs++;
            if (m_last) begin
                last_hs_cyc = cyc;
                n_last++;
            end
        end
        if (done) begin
            n_done++;
            done_cyc   = cyc;
            dr_at_done = desc_ready;
        end
    endtask

    // Offer a descriptor on the first cycle that desc_ready is high; k_cyc marks the cycle before edge E.
    task automatic issue_desc(input int a, input int l, input bit rdy);
        int t;
        t = 0;
        @(negedge clk);
        cyc++;
        desc_valid = 1'b0;
        m_ready    = rdy;
        while (!desc_ready && t < 20) begin
            @(negedge clk);
            cyc++;
            t++;
        end
        desc_valid = 1'b1;
        desc_addr  = 4'(a);
        desc_len   = 12'(l);
        k_cyc      = cyc;
    endtask

    task automatic run_burst(input int budget, input bit rnd, output bit to);
        for (int i = 0; i < budget; i++) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (n_done > 0) break;
        end
        to = (n_done == 0);
        repeat (3) step(1'b1);
    endtask

    task automatic test_reset();
        logic [44:0] outs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {desc_ready, ram_en, ram_addr, ram_regce, m_valid, m_data, m_last, busy, done};
        n_assert++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        #1;
        n_assert++;
        if (desc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: got %b expected 0", desc_ready);
        end
        @(negedge clk);
        n_assert++;
        if (desc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: got %b expected 1", desc_ready);
        end
    endtask

    task automatic test_basic();
        bit to;
        rec_clear();
        issue_desc(3, 5, 1'b1);
        run_burst(40, 1'b0, to);
        n_assert++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: done not seen within budget"); end
        n_assert++;
        if (first_en_cyc - k_cyc !== 1) begin
            n_fail++; $display("FAIL basic_first_ram_en: got offset %0d expected 1", first_en_cyc - k_cyc);
        end
        n_assert++;
        if (first_valid_cyc - k_cyc !== LAT + 2) begin
            n_fail++; $display("FAIL basic_first_valid: got offset %0d expected %0d", first_valid_cyc - k_cyc, LAT + 2);
        end
        n_assert++;
        if (addr_q.size() !== 5) begin
            n_fail++; $display("FAIL basic_read_count: got %0d expected 5", addr_q.size());
        end
        for (int i = 0; i < addr_q.size() && i < 5; i++) begin
            n_assert++;
            if (addr_q[i] !== 3 + i) begin
                n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addr_q[i], 3 + i);
            end
        end
        n_assert++;
        if (got_d.size() !== 5) begin
            n_fail++; $display("FAIL basic_word_count: got %0d expected 5", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_assert++;
            if (got_d[i] !== mem[3 + i] || got_l[i] !== (i == 4)) begin
                n_fail++; $display("FAIL basic_word[%0d]: got %h/last %0d expected %h/last %0d", i, got_d[i], got_l[i], mem[3 + i], (i == 4));
            end
        end
        n_assert++;
        if (last_hs_cyc - first_hs_cyc !== 4) begin
            n_fail++; $display("FAIL basic_no_bubbles: got span %0d expected 4", last_hs_cyc - first_hs_cyc);
        end
        n_assert++;
        if (done_cyc - last_hs_cyc !== 1 || n_done !== 1 || dr_at_done !== 1'b1) begin
            n_fail++; $display("FAIL basic_done: got offset %0d count %0d ready %b expected 1 1 1", done_cyc - last_hs_cyc, n_done, dr_at_done);
        end
        n_assert++;
        if (n_regce !== ((LAT == 2) ? 5 : 0)) begin
            n_fail++; $display("FAIL basic_regce: got %0d expected %0d", n_regce, (LAT == 2) ? 5 : 0);
        end
    endtask

    task automatic test_wrap();
        bit to;
        int exp_a [4];
        exp_a = '{14, 15, 0, 1};
        rec_clear();
        issue_desc(14, 4, 1'b1);
        run_burst(40, 1'b0, to);
        n_assert++;
        if (to || addr_q.size() !== 4 || got_d.size() !== 4) begin
            n_fail++; $display("FAIL wrap_counts: got timeout %0d reads %0d words %0d expected 0 4 4", to, addr_q.size(), got_d.size());
        end
        for (int i = 0; i < 4 && i < addr_q.size() && i < got_d.size(); i++) begin
            n_assert++;
            if (addr_q[i] !== exp_a[i] || got_d[i] !== mem[exp_a[i]]) begin
                n_fail++; $display("FAIL wrap[%0d]: got addr %0d data %h expected addr %0d data %h", i, addr_q[i], got_d[i], exp_a[i], mem[exp_a[i]]);
            end
        end
        n_assert++;
        if (n_last !== 1 || n_done !== 1) begin
            n_fail++; $display("FAIL wrap_last_done: got last %0d done %0d expected 1 1", n_last, n_done);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        rec_clear();
        issue_desc(2, 8, 1'b0);
        for (int i = 0; i < 10 && first_valid_cyc < 0; i++) step(1'b0);
        n_assert++;
        if (first_valid_cyc < 0) begin
            n_fail++; $display("FAIL bp_first_valid: got none expected m_valid within 10 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            n_assert++;
            if (m_valid !== 1'b1 || m_data !== mem[2]) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid %b data %h expected 1 %h", i, m_valid, m_data, mem[2]);
            end
        end
        n_assert++;
        if (n_issued !== 4 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_reads_stalled: got reads %0d ram_en %b expected 4 0", n_issued, ram_en);
        end
        run_burst(60, 1'b0, to);
        n_assert++;
        if (to || got_d.size() !== 8 || n_issued !== 8) begin
            n_fail++; $display("FAIL bp_counts: got timeout %0d words %0d reads %0d expected 0 8 8", to, got_d.size(), n_issued);
        end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            n_assert++;
            if (got_d[i] !== mem[2 + i]) begin
                n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_d[i], mem[2 + i]);
            end
        end
        n_assert++;
        if (n_last !== 1 || max_out > 4 || n_done !== 1) begin
            n_fail++; $display("FAIL bp_last_credit_done: got last %0d outstanding %0d done %0d expected 1 <=4 1", n_last, max_out, n_done);
        end
    endtask

    task automatic test_zero_len();
        rec_clear();
        issue_desc(5, 0, 1'b1);
        step(1'b1);
        n_assert++;
        if (desc_ready !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL zero_first_cycle: got ready %b done %b expected 0 1", desc_ready, done);
        end
        step(1'b1);
        n_assert++;
        if (desc_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL zero_second_cycle: got ready %b done %b expected 1 0", desc_ready, done);
        end
        repeat (4) step(1'b1);
        n_assert++;
        if (n_issued !== 0 || first_valid_cyc >= 0 || n_done !== 1 || n_busy !== 0) begin
            n_fail++; $display("FAIL zero_quiet: got reads %0d valid_at %0d done %0d busy %0d expected 0 -1 1 0", n_issued, first_valid_cyc, n_done, n_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [44:0] outs;
        rec_clear();
        issue_desc(8, 6, 1'b1);
        for (int i = 0; i < 20 && n_hs < 2; i++) step(1'b1);
        @(negedge clk);
        cyc++;
        #1;
        n_assert++;
        if (m_valid !== 1'b1 || m_data !== mem[10]) begin
            n_fail++; $display("FAIL mid_word3: got valid %b data %h expected 1 %h", m_valid, m_data, mem[10]);
        end
        rst_n = 1'b0;
        #1;
        outs = {desc_ready, ram_en, ram_addr, ram_regce, m_valid, m_data, m_last, busy, done};
        n_assert++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        rec_clear();
        issue_desc(0, 2, 1'b1);
        run_burst(40, 1'b0, to);
        n_assert++;
        if (to || got_d.size() !== 2 || n_issued !== 2 || n_done !== 1 || n_last !== 1) begin
            n_fail++; $display("FAIL mid_after_counts: got timeout %0d words %0d reads %0d done %0d last %0d expected 0 2 2 1 1", to, got_d.size(), n_issued, n_done, n_last);
        end
        for (int i = 0; i < got_d.size() && i < 2; i++) begin
            n_assert++;
            if (got_d[i] !== mem[i]) begin
                n_fail++; $display("FAIL mid_after_word[%0d]: got %h expected %h", i, got_d[i], mem[i]);
            end
        end
    endtask

    task automatic test_random_ready();
        bit to;
        int bad;
        rec_clear();
        issue_desc(0, 64, 1'b0);
        run_burst(1500, 1'b1, to);
        n_assert++;
        if (to || got_d.size() !== 64) begin
            n_fail++; $display("FAIL rand_counts: got timeout %0d words %0d expected 0 64", to, got_d.size());
        end
        bad = 0;
        for (int i = 0; i < got_d.size() && i < 64; i++) begin
            if (got_d[i] !== mem[i % 16] || got_l[i] !== (i == 63)) bad++;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rand_order: got %0d bad words expected 0", bad);
        end
        n_assert++;
        if (n_last !== 1 || max_out > 4 || n_done !== 1) begin
            n_fail++; $display("FAIL rand_last_credit_done: got last %0d outstanding %0d done %0d expected 1 <=4 1", n_last, max_out, n_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
        rec_clear();
        test_reset();
        test_basic();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
